// File: rtl/preset_clear_reg_bank.sv
// WIDTH-bit register with async clear/preset and shift, rotate, count modes.
// Ports: clk, clear0, preset0, en, mode, d, sin -> q, sout, carry, nand_out, all_ones, zero.
module preset_clear_reg_bank #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clear0,
  input  logic             preset0,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             carry,
  output logic             nand_out,
  output logic             all_ones,
  output logic             zero
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_UP   = 3'b110;
  localparam logic [2:0] M_DN   = 3'b111;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             sout_q;
  logic             sout_d;
  logic             carry_q;
  logic             carry_d;

  // Shifts are written with operators, not slices, so that
  // WIDTH == 1 degenerates naturally (shift -> sin, rotate -> hold).
  always_comb begin
    q_d     = q_q;
    sout_d  = sout_q;
    carry_d = 1'b0;
    if (en) begin
      unique case (mode)
        M_HOLD: begin
          q_d = q_q;
        end
        M_LOAD: begin
          q_d = d;
        end
        M_SHL: begin
          q_d    = (q_q << 1) | WIDTH'(sin);
          sout_d = q_q[MSB];
        end
        M_SHR: begin
          q_d    = (q_q >> 1) | (WIDTH'(sin) << MSB);
          sout_d = q_q[0];
        end
        M_ROL: begin
          q_d    = (q_q << 1) | (q_q >> MSB);
          sout_d = q_q[MSB];
        end
        M_ROR: begin
          q_d    = (q_q >> 1) | (q_q << MSB);
          sout_d = q_q[0];
        end
        M_UP: begin
          q_d     = q_q + WIDTH'(1);
          carry_d = &q_q;
        end
        M_DN: begin
          q_d     = q_q - WIDTH'(1);
          carry_d = ~|q_q;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // Clear dominates preset; both are asynchronous.
  always_ff @(posedge clk or negedge clear0 or negedge preset0) begin
    if (!clear0) begin
      q_q     <= '0;
      sout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (!preset0) begin
      q_q     <= PRESET_VAL;
      sout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      sout_q  <= sout_d;
      carry_q <= carry_d;
    end
  end

  assign q        = q_q;
  assign sout     = sout_q;
  assign carry    = carry_q;
  assign nand_out = ~&q_q;
  assign all_ones = &q_q;
  assign zero     = ~|q_q;

endmodule
